// File: rtl/sliding_window_gen_pkg.sv
// rtl/sliding_window_gen_pkg.sv - shared types and helpers for the sliding-window generator
package sliding_window_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Bounded loop so the helper stays usable in constant and synthesis contexts.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/sliding_window_gen_line_buffer.sv
// rtl/sliding_window_gen_line_buffer.sv - DIM-deep circular line delay, one shared read/write pointer
// dout is the value written DIM enables ago; contents are never cleared.
module sliding_window_gen_line_buffer
  import sliding_window_gen_pkg::*;
#(
  parameter int W   = 8,
  parameter int DIM = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int AW = clog2(DIM);

  logic [W-1:0]  mem_q [DIM];
  logic [AW-1:0] ptr_q, ptr_d;

  assign dout  = mem_q[ptr_q];
  assign ptr_d = (ptr_q == AW'(DIM - 1)) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr_q <= '0;
    else if (en) ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= din;
  end

endmodule

// File: rtl/sliding_window_gen.sv
// rtl/sliding_window_gen.sv - KxK sliding-window generator over a DIMxDIM raster frame
// SWIN_ZERO_PAD_EN: same-size zero-padded output (DIM*DIM windows); default is valid-only output.
module sliding_window_gen
  import sliding_window_gen_pkg::*;
#(
  parameter int W   = 8,
  parameter int K   = 5,
  parameter int DIM = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [K*K*W-1:0]        out_win,
  output logic [clog2(DIM)-1:0]   out_x,
  output logic [clog2(DIM)-1:0]   out_y,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int H    = K / 2;
  localparam int CW   = clog2(DIM);
  localparam int XW   = CW + 1;
  localparam int NPIX = DIM * DIM;
`ifdef SWIN_ZERO_PAD_EN
  localparam int OFF  = H * DIM + H;
  localparam int PW   = clog2(NPIX + OFF + 1);
`else
  localparam int PW   = clog2(NPIX + 1);
`endif

  state_e              state_q, state_d;
  logic [PW-1:0]       p_q, p_d;
  logic [XW-1:0]       px_q, px_d, py_q, py_d;
  logic [W-1:0]        taps_q [K][K];
  logic [W-1:0]        taps_d [K][K];
  logic [W-1:0]        lb_in  [K-1];
  logic [W-1:0]        lb_out [K-1];
  logic                out_valid_q, out_valid_d;
  logic [K*K*W-1:0]    win_q, win_d, win_new;
  logic [CW-1:0]       ox_q, ox_d, oy_q, oy_d;
  logic [CW-1:0]       ccx, ccy;
  logic [W-1:0]        pix;
  logic                adv, emit, last_in;

  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign pix      = (state_q == S_RUN) ? in_data : '0;
  assign last_in  = (p_q == PW'(NPIX - 1));

`ifdef SWIN_ZERO_PAD_EN
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic          flush_last;
  assign flush_last = (p_q == PW'(NPIX + OFF - 1));
  assign adv  = (in_ready && in_valid) || (state_q == S_FLUSH && (!out_valid_q || out_ready));
  assign emit = (p_q >= PW'(OFF));
  assign ccx  = cx_q;
  assign ccy  = cy_q;
`else
  assign adv  = in_ready && in_valid;
  assign emit = (px_q >= XW'(K - 1)) && (py_q >= XW'(K - 1));
  assign ccx  = CW'(px_q - XW'(H));
  assign ccy  = CW'(py_q - XW'(H));
`endif

  // Line buffer i delays by (i+1) rows and feeds the rightmost column of tap row K-2-i.
  assign lb_in[0] = pix;
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i > 0) begin : g_chain
      assign lb_in[i] = lb_out[i-1];
    end
    sliding_window_gen_line_buffer #(.W(W), .DIM(DIM)) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .din  (lb_in[i]),
      .dout (lb_out[i])
    );
  end

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) taps_d[r][c] = taps_q[r][c+1];
    end
    for (int r = 0; r < K - 1; r++) taps_d[r][K-1] = lb_out[K-2-r];
    taps_d[K-1][K-1] = pix;
  end

  always_ff @(posedge clk) begin
    if (adv) taps_q <= taps_d;
  end

  // Masking by centre coordinate also removes row-wrapped neighbours and stale buffer data.
  always_comb begin
    logic [XW-1:0] sx, sy;
    win_new = '0;
    sx      = '0;
    sy      = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        sx = {1'b0, ccx} + XW'(c);
        sy = {1'b0, ccy} + XW'(r);
        if (sx >= XW'(H) && sx < XW'(DIM + H) && sy >= XW'(H) && sy < XW'(DIM + H))
          win_new[win_idx(r, c, K)*W +: W] = taps_d[r][c];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
`ifdef SWIN_ZERO_PAD_EN
      S_RUN:   if (adv && last_in) state_d = S_FLUSH;
      S_FLUSH: if (adv && flush_last) state_d = S_DRAIN;
`else
      S_RUN:   if (adv && last_in) state_d = S_DRAIN;
`endif
      S_DRAIN: begin
        if (!out_valid_q) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p_d  = p_q;
    px_d = px_q;
    py_d = py_q;
`ifdef SWIN_ZERO_PAD_EN
    cx_d = cx_q;
    cy_d = cy_q;
`endif
    if (state_q == S_IDLE && start) begin
      p_d  = '0;
      px_d = '0;
      py_d = '0;
`ifdef SWIN_ZERO_PAD_EN
      cx_d = '0;
      cy_d = '0;
`endif
    end else if (adv) begin
      p_d = p_q + 1'b1;
      if (px_q == XW'(DIM - 1)) begin
        px_d = '0;
        py_d = py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
`ifdef SWIN_ZERO_PAD_EN
      if (emit) begin
        if (cx_q == CW'(DIM - 1)) begin
          cx_d = '0;
          cy_d = cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
`endif
    end
  end

  // adv is only possible when the output stage is empty or draining, so a held window is never overwritten.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    win_d       = win_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    if (adv && emit) begin
      out_valid_d = 1'b1;
      win_d       = win_new;
      ox_d        = ccx;
      oy_d        = ccy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      out_valid_q <= 1'b0;
      win_q       <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
`ifdef SWIN_ZERO_PAD_EN
      cx_q        <= '0;
      cy_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      px_q        <= px_d;
      py_q        <= py_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
`ifdef SWIN_ZERO_PAD_EN
      cx_q        <= cx_d;
      cy_q        <= cy_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_win   = win_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sliding_window_gen.sv
// tb/tb_sliding_window_gen.sv - scoreboard bench for sliding_window_gen (W=8, K=5, DIM=32)
module tb_sliding_window_gen;

  localparam int W    = 8;
  localparam int K    = 5;
  localparam int DIM  = 32;
  localparam int H    = K / 2;
  localparam int CW   = $clog2(DIM);
  localparam int KKW  = K * K * W;
  localparam int NPIX = DIM * DIM;
  localparam int OFF  = H * DIM + H;
`ifdef SWIN_ZERO_PAD_EN
  localparam int EXP_TOTAL = NPIX;
  localparam int CAP_X = 0, CAP_Y = 5;
`else
  localparam int EXP_TOTAL = (DIM - K + 1) * (DIM - K + 1);
  localparam int CAP_X = 2, CAP_Y = 5;
`endif

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready, busy, frame_done;
  logic [W-1:0]   in_data;
  logic [KKW-1:0] out_win;
  logic [CW-1:0]  out_x, out_y;

  int errors = 0;
  int checks = 0;
  int qx[$], qy[$];
  int nwin, ndone, stall_left;
  bit cap_seen;
  logic [KKW-1:0] first_win, last_win, cap_win;
  int first_x, first_y, last_x, last_y;

  sliding_window_gen #(.W(W), .K(K), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
    .out_x(out_x), .out_y(out_y), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix_val(input int x, input int y);
    int v;
    v = y * DIM + x + 1;
    return v[7:0];
  endfunction

  function automatic logic [W-1:0] tap(input logic [KKW-1:0] w, input int r, input int c);
    return w[(r*K+c)*W +: W];
  endfunction

  function automatic logic [KKW-1:0] exp_win(input int cx, input int cy);
    logic [KKW-1:0] v;
    int sx, sy;
    v = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        sx = cx - H + c;
        sy = cy - H + r;
        if (sx >= 0 && sx < DIM && sy >= 0 && sy < DIM) v[(r*K+c)*W +: W] = pix_val(sx, sy);
      end
    end
    return v;
  endfunction

  // Drives one frame; expected centres are queued as pixels are accepted and popped on consumption.
  task automatic run_frame(input bit rnd, input int stall_at, input int abort_at, input int restart_at);
    int  pidx;
    bit  done, restarted, stall_now;
    logic [KKW-1:0] ew;
    qx.delete(); qy.delete();
    nwin = 0; ndone = 0; pidx = 0; done = 0; restarted = 0; stall_left = 10; cap_seen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %0b want 1", busy); end
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      in_valid  = (pidx < NPIX) && (!rnd || $urandom_range(0, 3) != 0);
      in_data   = (pidx < NPIX) ? pix_val(pidx % DIM, pidx / DIM) : '0;
      stall_now = (stall_at >= 0) && (nwin == stall_at) && (stall_left > 0);
      if (stall_now)  out_ready = 1'b0;
      else if (rnd)   out_ready = 1'($urandom_range(0, 1));
      else            out_ready = 1'b1;
      start = (restart_at >= 0) && !restarted && (pidx >= restart_at);
      if (start) restarted = 1;
      #1;
      if (stall_now && out_valid === 1'b1 && qx.size() > 0) begin
        ew = exp_win(qx[0], qy[0]);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %0b want 0", in_ready); end
        checks++;
        if (out_win !== ew || out_x !== CW'(qx[0]) || out_y !== CW'(qy[0])) begin
          errors++; $display("FAIL stall_hold: got (%0d,%0d) %h want (%0d,%0d) %h", out_x, out_y, out_win, qx[0], qy[0], ew);
        end
        stall_left--;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (qx.size() == 0) begin
          errors++; $display("FAIL extra_window: got centre (%0d,%0d) want none", out_x, out_y);
        end else begin
          ew = exp_win(qx[0], qy[0]);
          if (out_win !== ew || out_x !== CW'(qx[0]) || out_y !== CW'(qy[0])) begin
            errors++; $display("FAIL window_%0d: got (%0d,%0d) %h want (%0d,%0d) %h", nwin, out_x, out_y, out_win, qx[0], qy[0], ew);
          end
          if (nwin == 0) begin first_win = out_win; first_x = out_x; first_y = out_y; end
          last_win = out_win; last_x = out_x; last_y = out_y;
          if (qx[0] == CAP_X && qy[0] == CAP_Y) begin cap_win = out_win; cap_seen = 1; end
          void'(qx.pop_front()); void'(qy.pop_front());
        end
        nwin++;
      end
      if (frame_done === 1'b1) begin
        ndone++; done = 1;
        checks++; if (qx.size() != 0) begin errors++; $display("FAIL done_early: got %0d pending want 0", qx.size()); end
      end
      if (in_valid && in_ready === 1'b1) begin
`ifdef SWIN_ZERO_PAD_EN
        if (pidx >= OFF) begin qx.push_back((pidx - OFF) % DIM); qy.push_back((pidx - OFF) / DIM); end
        pidx++;
        if (pidx == NPIX) begin
          for (int c = NPIX - OFF; c < NPIX; c++) begin qx.push_back(c % DIM); qy.push_back(c / DIM); end
        end
`else
        if (pidx % DIM >= K - 1 && pidx / DIM >= K - 1) begin
          qx.push_back(pidx % DIM - H); qy.push_back(pidx / DIM - H);
        end
        pidx++;
`endif
        if (abort_at >= 0 && pidx == abort_at) begin
          @(negedge clk);
          rst = 1'b1; in_valid = 1'b0; start = 1'b0;
          #1;
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %0b want 0", out_valid); end
          checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %0b want 0", in_ready); end
          checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL abort_frame_done: got %0b want 0", frame_done); end
          checks++; if (out_win !== '0 || out_x !== '0 || out_y !== '0) begin
            errors++; $display("FAIL abort_outputs: got (%0d,%0d) %h want zero", out_x, out_y, out_win);
          end
          @(negedge clk); rst = 1'b0;
          qx.delete(); qy.delete();
          return;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++; $display("FAIL frame_timeout: got %0d windows want frame_done", nwin);
    end
    @(negedge clk); #1;
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %0b want 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %0b want 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
    checks++; if (out_win !== '0) begin errors++; $display("FAIL reset_out_win: got %h want 0", out_win); end
    checks++; if (out_x !== '0 || out_y !== '0) begin errors++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", out_x, out_y); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_frame();
    run_frame(0, -1, -1, -1);
    checks++; if (nwin != EXP_TOTAL) begin errors++; $display("FAIL full_count: got %0d want %0d", nwin, EXP_TOTAL); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL full_done: got %0d want 1", ndone); end
    checks++; if (!cap_seen) begin errors++; $display("FAIL cap_seen: got 0 want 1"); end
`ifdef SWIN_ZERO_PAD_EN
    checks++; if (first_x != 0 || first_y != 0) begin errors++; $display("FAIL first_centre: got (%0d,%0d) want (0,0)", first_x, first_y); end
    checks++; if (tap(first_win,0,0) !== 8'd0) begin errors++; $display("FAIL first_tap00: got %0d want 0", tap(first_win,0,0)); end
    checks++; if (tap(first_win,2,2) !== 8'd1) begin errors++; $display("FAIL first_tap22: got %0d want 1", tap(first_win,2,2)); end
    checks++; if (tap(first_win,4,4) !== 8'd67) begin errors++; $display("FAIL first_tap44: got %0d want 67", tap(first_win,4,4)); end
    checks++; if (last_x != 31 || last_y != 31) begin errors++; $display("FAIL last_centre: got (%0d,%0d) want (31,31)", last_x, last_y); end
    checks++; if (tap(last_win,2,2) !== 8'd0) begin errors++; $display("FAIL last_tap22: got %0d want 0", tap(last_win,2,2)); end
    checks++; if (tap(last_win,1,1) !== 8'd223) begin errors++; $display("FAIL last_tap11: got %0d want 223", tap(last_win,1,1)); end
    checks++; if (tap(last_win,2,3) !== 8'd0) begin errors++; $display("FAIL last_tap23: got %0d want 0", tap(last_win,2,3)); end
    checks++; if (tap(cap_win,2,0) !== 8'd0 || tap(cap_win,2,1) !== 8'd0) begin
      errors++; $display("FAIL row_wrap: got %0d,%0d want 0,0", tap(cap_win,2,0), tap(cap_win,2,1));
    end
    checks++; if (tap(cap_win,2,2) !== 8'd161) begin errors++; $display("FAIL wrap_tap22: got %0d want 161", tap(cap_win,2,2)); end
    checks++; if (tap(cap_win,0,2) !== 8'd97) begin errors++; $display("FAIL wrap_tap02: got %0d want 97", tap(cap_win,0,2)); end
`else
    checks++; if (first_x != 2 || first_y != 2) begin errors++; $display("FAIL first_centre: got (%0d,%0d) want (2,2)", first_x, first_y); end
    checks++; if (tap(first_win,0,0) !== 8'd1) begin errors++; $display("FAIL first_tap00: got %0d want 1", tap(first_win,0,0)); end
    checks++; if (tap(first_win,2,2) !== 8'd67) begin errors++; $display("FAIL first_tap22: got %0d want 67", tap(first_win,2,2)); end
    checks++; if (tap(first_win,4,4) !== 8'd133) begin errors++; $display("FAIL first_tap44: got %0d want 133", tap(first_win,4,4)); end
    checks++; if (last_x != 29 || last_y != 29) begin errors++; $display("FAIL last_centre: got (%0d,%0d) want (29,29)", last_x, last_y); end
    checks++; if (tap(last_win,2,2) !== 8'd190) begin errors++; $display("FAIL last_tap22: got %0d want 190", tap(last_win,2,2)); end
    checks++; if (tap(cap_win,0,0) !== 8'd97) begin errors++; $display("FAIL cap_tap00: got %0d want 97", tap(cap_win,0,0)); end
    checks++; if (tap(cap_win,4,0) !== 8'd225) begin errors++; $display("FAIL cap_tap40: got %0d want 225", tap(cap_win,4,0)); end
    checks++; if (tap(cap_win,2,2) !== 8'd163) begin errors++; $display("FAIL cap_tap22: got %0d want 163", tap(cap_win,2,2)); end
`endif
  endtask

  task automatic test_backpressure();
    run_frame(0, 100, -1, -1);
    checks++; if (stall_left != 0) begin errors++; $display("FAIL stall_cycles: got %0d left want 0", stall_left); end
    checks++; if (nwin != EXP_TOTAL) begin errors++; $display("FAIL stall_count: got %0d want %0d", nwin, EXP_TOTAL); end
  endtask

  task automatic test_random_ready();
    run_frame(1, -1, -1, -1);
    checks++; if (nwin != EXP_TOTAL) begin errors++; $display("FAIL random_count: got %0d want %0d", nwin, EXP_TOTAL); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL random_done: got %0d want 1", ndone); end
  endtask

  task automatic test_abort_restart();
    run_frame(0, -1, 500, -1);
    run_frame(0, -1, -1, 300);
    checks++; if (nwin != EXP_TOTAL) begin errors++; $display("FAIL restart_count: got %0d want %0d", nwin, EXP_TOTAL); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL restart_done: got %0d want 1", ndone); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_random_ready();
    test_abort_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
